// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and serial-link constants for the pattern generator and detector
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} seq_state_t;
  localparam int PATTERN_WIDTH = 4;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
  localparam int GAP_CYCLES = 2;
  localparam int REPEAT_W = 4;
  localparam int GAP_W = 4;
endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: parallel-load shift-left register exposing its MSB as the serial tap
module seq_shift_reg #(
  parameter int W = 4
)(
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);
  logic [W-1:0] r_q;
  // load wins over shift so a reload on the last bit starts the next copy cleanly
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) r_q <= '0;
    else if (i_load) r_q <= i_data;
    else if (i_shift) r_q <= {r_q[W-2:0], 1'b0};
  assign o_msb = r_q[W-1];
endmodule

// File: rtl/sequence_generator_moore.sv
// sequence_generator_moore: Moore FSM sending a captured word MSB-first with optional gapped repeats
module sequence_generator_moore import seq_pkg::*; #(
  parameter int PATTERN_WIDTH = seq_pkg::PATTERN_WIDTH,
  parameter logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = PATTERN_WIDTH'(seq_pkg::DEFAULT_PATTERN),
  parameter int GAP_CYCLES = seq_pkg::GAP_CYCLES
)(
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_use_default,
  input  logic [PATTERN_WIDTH-1:0] i_pattern_in,
  input  logic [REPEAT_W-1:0]      i_repeat_count,
  output logic                     o_sequence_out,
  output logic                     o_bit_valid,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int CW = $clog2(PATTERN_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(PATTERN_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  seq_state_t r_state, w_state_nx;
  logic [PATTERN_WIDTH-1:0] r_word, w_word_nx, w_load_word, w_sel;
  logic [CW-1:0] r_bit_cnt, w_bit_nx;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nx;
  logic [REPEAT_W-1:0] r_reps, w_reps_nx;
  logic w_load, w_shift, w_msb;
  assign w_sel = i_use_default ? DEFAULT_PATTERN : i_pattern_in;
  // state and counter registers; reset aborts any transaction without a done pulse
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_reps    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_word    <= w_word_nx;
      r_bit_cnt <= w_bit_nx;
      r_gap_cnt <= w_gap_nx;
      r_reps    <= w_reps_nx;
    end
  // next-state, counter updates and shift-register control
  always_comb begin
    w_state_nx  = r_state;
    w_word_nx   = r_word;
    w_bit_nx    = r_bit_cnt;
    w_gap_nx    = r_gap_cnt;
    w_reps_nx   = r_reps;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_word = r_word;
    case (r_state)
      IDLE: if (i_start) begin
        w_state_nx  = SEND;
        w_load      = 1'b1;
        w_load_word = w_sel;
        w_word_nx   = w_sel;
        w_bit_nx    = LAST_BIT;
        w_reps_nx   = i_repeat_count;
      end
      SEND: begin
        w_shift = 1'b1;
        if (r_bit_cnt != '0) w_bit_nx = r_bit_cnt - 1'b1;
        else if (r_reps != '0) begin
          w_load     = 1'b1;
          w_bit_nx   = LAST_BIT;
          w_reps_nx  = r_reps - 1'b1;
          w_gap_nx   = GAP_LOAD;
          w_state_nx = GAP_CYCLES > 0 ? GAP : SEND;
        end else w_state_nx = DONE;
      end
      GAP: begin
        w_gap_nx   = r_gap_cnt == '0 ? r_gap_cnt : r_gap_cnt - 1'b1;
        w_state_nx = r_gap_cnt == '0 ? SEND : GAP;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  seq_shift_reg #(.W(PATTERN_WIDTH)) u_shift (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_data   (w_load_word),
    .o_msb    (w_msb)
  );
  assign o_sequence_out = (r_state == SEND) & w_msb;
  assign o_bit_valid    = r_state == SEND;
  assign o_busy         = r_state != IDLE;
  assign o_done         = r_state == DONE;
endmodule

// File: tb/tb_sequence_generator_moore.sv
// tb_sequence_generator_moore: checks a gapped build and a back-to-back build against a frame-list model
module tb_sequence_generator_moore;
  import seq_pkg::*;
  localparam int PW = 4;
  typedef logic [3:0] ent_q_t[$];
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, use_def = 1'b0;
  logic [PW-1:0] pat = '0;
  logic [3:0] rep = '0;
  logic so_a, bv_a, bz_a, dn_a, so_b, bv_b, bz_b, dn_b;
  int total = 0, bad = 0, busy_cnt;
  ent_q_t qa, qb;
  always #5 clk = ~clk;
  sequence_generator_moore u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_use_default(use_def),
    .i_pattern_in(pat), .i_repeat_count(rep),
    .o_sequence_out(so_a), .o_bit_valid(bv_a), .o_busy(bz_a), .o_done(dn_a));
  sequence_generator_moore #(.GAP_CYCLES(0)) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_use_default(use_def),
    .i_pattern_in(pat), .i_repeat_count(rep),
    .o_sequence_out(so_b), .o_bit_valid(bv_b), .o_busy(bz_b), .o_done(dn_b));
  // expected per-cycle {sequence_out, bit_valid, busy, done} for one whole transaction
  function automatic ent_q_t build(input logic [PW-1:0] w, input int r, input int gap);
    ent_q_t q;
    for (int c = 0; c <= r; c++) begin
      for (int b = PW - 1; b >= 0; b--) q.push_back({w[b], 3'b110});
      if (c < r) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0011);
    return q;
  endfunction
  task automatic check();
    logic [3:0] ea, eb;
    ea = qa.size() != 0 ? qa[0] : 4'b0000;
    eb = qb.size() != 0 ? qb[0] : 4'b0000;
    total++;
    assert ({so_a, bv_a, bz_a, dn_a} === ea)
      else begin bad++; $error("FAIL gap2 obs=%b exp=%b t=%0t", {so_a, bv_a, bz_a, dn_a}, ea, $time); end
    total++;
    assert ({so_b, bv_b, bz_b, dn_b} === eb)
      else begin bad++; $error("FAIL gap0 obs=%b exp=%b t=%0t", {so_b, bv_b, bz_b, dn_b}, eb, $time); end
  endtask
  task automatic step();
    logic [PW-1:0] w;
    @(posedge clk);
    if (rst_n) begin
      w = use_def ? DEFAULT_PATTERN : pat;
      if (qa.size() == 0) begin if (start) qa = build(w, int'(rep), 2); end
      else void'(qa.pop_front());
      if (qb.size() == 0) begin if (start) qb = build(w, int'(rep), 0); end
      else void'(qb.pop_front());
    end
    #1;
    check();
  endtask
  initial begin
    step();
    step();
    rst_n = 1'b1;
    step();
    use_def = 1'b1; rep = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    use_def = 1'b0; pat = 4'b0110; rep = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = int'(bz_a);
    for (int i = 0; i < 20; i++) begin
      pat = PW'($urandom);
      step();
      busy_cnt += int'(bz_a);
    end
    total++;
    assert (busy_cnt == 3 * PW + 2 * 2 + 1)
      else begin bad++; $error("FAIL busy_len obs=%0d exp=%0d", busy_cnt, 3 * PW + 2 * 2 + 1); end
    use_def = 1'b1; rep = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    rep = 4'd2; start = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      start = 1'($urandom);
      step();
    end
    start = 1'b0;
    repeat (8) step();
    rep = 4'd0; use_def = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1 check();
    start = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    start = 1'b1;
    repeat (20) step();
    start = 1'b0;
    repeat (6) step();
    for (int t = 0; t < 30; t++) begin
      pat = PW'($urandom); use_def = 1'($urandom); rep = 4'($urandom_range(0, 3)); start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < int'($urandom_range(0, 30)); i++) begin
        pat = PW'($urandom);
        start = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    start = 1'b0;
    repeat (40) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sequence_generator_moore.md
# sequence_generator_moore

Moore-style serial pattern transmitter that drives the `sequence_in` input of the sequence detector. On a start request it shifts a PATTERN_WIDTH-bit word out MSB-first, one bit per clock. It optionally repeats the word with idle gaps between copies, then pulses `done`. It sits upstream of the detector as the stimulus/transmit end of the same single-wire serial interface, both in benches and in the top-level loopback.

## Interface
- PATTERN_WIDTH, 4, bits per word; legal range 2..16
- DEFAULT_PATTERN, 4'b1011, word sent when `use_default` = 1; width PATTERN_WIDTH
- GAP_CYCLES, 2, idle (0) cycles inserted between repeated words; 0..15, 0 = back-to-back
- clock  input  1  rising-edge clock, single domain
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising edge only in IDLE
- use_default  input  1  1 = send DEFAULT_PATTERN, 0 = send `pattern_in`; sampled with `start`
- pattern_in  input  PATTERN_WIDTH  word to send, sampled with `start`
- repeat_count  input  4  additional copies after the first (0 = send once); sampled with `start`
- sequence_out  output  1  serial data, MSB first; 0 when not sending
- bit_valid  output  1  1 while `sequence_out` carries a pattern bit
- busy  output  1  1 in every state except IDLE
- done  output  1  one-cycle pulse after the last bit of the last copy

## Operation
- States: IDLE, SEND, GAP, DONE. All outputs are decoded from registered state/shift register only (Moore); no input-to-output combinational path.
- IDLE: outputs 0. On an edge with `start`=1: load shift register (selected word), bit counter = PATTERN_WIDTH-1, repeats_left = `repeat_count`; go to SEND.
- SEND: `sequence_out` = shift register MSB, `bit_valid` = 1. Each edge shifts left, counter decrements. On the edge where counter = 0:
  - repeats_left > 0 and GAP_CYCLES > 0 → GAP, gap counter = GAP_CYCLES-1, reload shift register from the captured word, repeats_left decrements.
  - repeats_left > 0 and GAP_CYCLES = 0 → stay in SEND, reload, repeats_left decrements. There are no idle bits between copies.
  - repeats_left = 0 → DONE.
- GAP: `sequence_out` = 0, `bit_valid` = 0, `busy` = 1. Gap counter decrements. At 0, go to SEND with counter = PATTERN_WIDTH-1.
- DONE: `done` = 1, `busy` = 1, `sequence_out` = 0. Unconditionally go to IDLE next edge.
- `start` is ignored outside IDLE. `start` held high continuously produces back-to-back transactions separated by the DONE and IDLE cycles.
- Captured word is held in a separate register so repeats are unaffected by `pattern_in` changes mid-transaction.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream): state = IDLE; all outputs 0; all counters 0. Reset mid-transaction aborts immediately, with no `done` pulse.
- Start sampled at edge k: bit PATTERN_WIDTH-1 on `sequence_out` during the cycle after edge k. A downstream detector samples it at edge k+1.
- One copy occupies exactly PATTERN_WIDTH cycles. Total busy cycles = (R+1)·PATTERN_WIDTH + R·GAP_CYCLES + 1 (DONE), where R = `repeat_count`.
- `done` high for exactly one cycle, in the cycle immediately following the last data bit. The earliest next accepted `start` is 2 edges after the last data bit (DONE→IDLE, then sample).
- Counters are unsigned, sized $clog2 of their max value (bit counter ≥1 bit, gap counter 4 bits, repeats 4 bits). No wrap occurs because each counter reaches 0 before reload.

## Structure
- Shared package `seq_pkg`: state enum (IDLE, SEND, GAP, DONE), DEFAULT_PATTERN constant 4'b1011, and width constants also used by the detector and its bench.
- One natural sub-module, `seq_shift_reg`: parallel-load, shift-left register with MSB tap and load/shift enables. The FSM and counters live in the top module.

## Test plan
- Reset then `start`=1 for one cycle, `use_default`=1, R=0 → `sequence_out` = 1,0,1,1 on the 4 cycles after the start edge. `bit_valid` high for those 4 cycles, `done` pulse on cycle 5, and the detector's `detector_out` asserts once.
- `pattern_in`=4'b0110, `use_default`=0, R=2, GAP=2 → 0110 00 0110 00 0110, then `done`. `busy` is high for 17 cycles; `pattern_in` changed mid-run has no effect.
- GAP_CYCLES=0 build, R=1, default pattern → 10111011 contiguous, `bit_valid` never drops, and the detector fires twice.
- `start` pulsed again during SEND and GAP → ignored; the output stream is identical to a single-start run.
- Assert `reset_n`=0 asynchronously (between edges) during the second bit → outputs 0 immediately, no `done`. After release, a new `start` transmits the full word from the MSB.
- `start` held high for 20 cycles, R=0 → repeating frames of 4 data bits plus DONE and IDLE. `done` pulses every 6 cycles.
